// File: rtl/pc_src_ctrl_pkg.sv
// Shared encodings for the PC-source sequencer: request kinds, mux selects, causes, FSM states.
package pc_src_ctrl_pkg;

   typedef enum logic [2:0] {
      KindNext   = 3'd0,
      KindBranch = 3'd1,
      KindJump   = 3'd2,
      KindJr     = 3'd3,
      KindRte    = 3'd4
   } reqKindT;

   // Mux input 6 exists in the datapath but is never selected here.
   typedef enum logic [2:0] {
      SelPc4     = 3'd0,
      SelAluOut  = 3'd1,
      SelJump    = 3'd2,
      SelRs      = 3'd3,
      SelEpc     = 3'd4,
      SelMemByte = 3'd5
   } pcSelT;

   typedef enum logic [1:0] {
      CauseNone   = 2'd0,
      CauseOpcode = 2'd1,
      CauseOvf    = 2'd2,
      CauseDiv0   = 2'd3
   } causeT;

   typedef enum logic [2:0] {
      StIdle,
      StUpdate,
      StExcEpc,
      StExcRd,
      StExcWait,
      StExcLoad
   } stateT;

   // Highest-priority exception wins: opcode, then overflow, then divide-by-zero.
   function automatic causeT excCause(input logic opc, input logic ovf, input logic div0);
      if (opc)       return CauseOpcode;
      else if (ovf)  return CauseOvf;
      else if (div0) return CauseDiv0;
      else           return CauseNone;
   endfunction

endpackage

// File: rtl/pc_src_ctrl_if.sv
// Request/response bundle between the main control FSM and the PC-source sequencer.
interface pc_src_ctrl_if;

   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_kind;
   logic       branch_taken;
   logic       exc_opcode;
   logic       exc_ovf;
   logic       exc_div0;
   logic [2:0] pc_src_sel;
   logic       pc_write;
   logic       epc_write;
   logic       mem_rd;
   logic [7:0] exc_addr;
   logic [1:0] cause;
   logic       done;

   modport master (
      output req_valid, req_kind, branch_taken, exc_opcode, exc_ovf, exc_div0,
      input  req_ready, pc_src_sel, pc_write, epc_write, mem_rd, exc_addr, cause, done
   );

   modport slave (
      input  req_valid, req_kind, branch_taken, exc_opcode, exc_ovf, exc_div0,
      output req_ready, pc_src_sel, pc_write, epc_write, mem_rd, exc_addr, cause, done
   );

endinterface

// File: rtl/pc_src_ctrl.sv
// Sequences PC-source mux select, PC/EPC writes and the exception vector fetch.
// Every output is a register loaded from the next-state decode.
module pc_src_ctrl
   import pc_src_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT  = 1,
   parameter logic [7:0]  EXC_BASE = 8'd253
) (
   input  logic          clk,
   input  logic          reset_n,
   pc_src_ctrl_if.slave  bus
);

   localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);

   stateT      stateQ, stateD;
   logic [2:0] cntQ, cntD;
   causeT      causeQ, causeD;
   logic [2:0] selQ, selD;
   logic       pcWriteQ, pcWriteD;
   logic       doneQ, doneD;
   logic       readyQ, epcWriteQ, memRdQ;
   logic [7:0] excAddrQ;
   logic [7:0] vecAddr;
   logic       anyExc;

   assign anyExc  = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;
   // causeQ is already latched by the time the read state is entered.
   assign vecAddr = EXC_BASE + {6'd0, causeQ} - 8'd1;

   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      causeD   = causeQ;
      selD     = selQ;
      pcWriteD = 1'b0;
      doneD    = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (bus.req_valid) begin
               causeD = excCause(bus.exc_opcode, bus.exc_ovf, bus.exc_div0);
               if (anyExc) begin
                  stateD = StExcEpc;
               end else begin
                  stateD   = StUpdate;
                  doneD    = 1'b1;
                  pcWriteD = 1'b1;
                  case (bus.req_kind)
                     KindBranch: begin
                        if (bus.branch_taken) selD = SelAluOut;
                        else                  pcWriteD = 1'b0;
                     end
                     KindJump: selD = SelJump;
                     KindJr:   selD = SelRs;
                     KindRte:  selD = SelEpc;
                     default:  selD = SelPc4;
                  endcase
               end
            end
         end
         StUpdate: stateD = StIdle;
         StExcEpc: stateD = StExcRd;
         StExcRd: begin
            stateD = StExcWait;
            cntD   = LatInit;
         end
         StExcWait: begin
            if (cntQ == 3'd0) begin
               stateD   = StExcLoad;
               selD     = SelMemByte;
               pcWriteD = 1'b1;
               doneD    = 1'b1;
            end else begin
               cntD = cntQ - 3'd1;
            end
         end
         StExcLoad: stateD = StIdle;
         default:   stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ    <= StIdle;
         cntQ      <= 3'd0;
         causeQ    <= CauseNone;
         selQ      <= SelPc4;
         pcWriteQ  <= 1'b0;
         doneQ     <= 1'b0;
         readyQ    <= 1'b1;
         epcWriteQ <= 1'b0;
         memRdQ    <= 1'b0;
         excAddrQ  <= 8'd0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         causeQ    <= causeD;
         selQ      <= selD;
         pcWriteQ  <= pcWriteD;
         doneQ     <= doneD;
         readyQ    <= (stateD == StIdle);
         epcWriteQ <= (stateD == StExcEpc);
         memRdQ    <= (stateD == StExcRd);
         excAddrQ  <= (stateD == StExcRd) ? vecAddr : 8'd0;
      end
   end

   assign bus.req_ready  = readyQ;
   assign bus.pc_src_sel = selQ;
   assign bus.pc_write   = pcWriteQ;
   assign bus.epc_write  = epcWriteQ;
   assign bus.mem_rd     = memRdQ;
   assign bus.exc_addr   = excAddrQ;
   assign bus.cause      = causeQ;
   assign bus.done       = doneQ;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Bench for pc_src_ctrl: two instances (MEM_LAT 1 and 3) share stimulus; a timeline model
// predicts every output each cycle, and directed literal checks pin the model.
module tb_pc_src_ctrl;

   localparam int N = 1024;

   logic       clk;
   logic       reset_n;
   logic       reqValid, taken, excOpc, excOvf, excDiv0;
   logic [2:0] reqKind;

   int nCmp  = 0;
   int nFail = 0;
   int cyc   = 0;

   pc_src_ctrl_if ifa ();
   pc_src_ctrl_if ifb ();

   assign ifa.req_valid    = reqValid;
   assign ifa.req_kind     = reqKind;
   assign ifa.branch_taken = taken;
   assign ifa.exc_opcode   = excOpc;
   assign ifa.exc_ovf      = excOvf;
   assign ifa.exc_div0     = excDiv0;
   assign ifb.req_valid    = reqValid;
   assign ifb.req_kind     = reqKind;
   assign ifb.branch_taken = taken;
   assign ifb.exc_opcode   = excOpc;
   assign ifb.exc_ovf      = excOvf;
   assign ifb.exc_div0     = excDiv0;

   pc_src_ctrl #(.MEM_LAT(1), .EXC_BASE(8'd253)) dutA (.clk(clk), .reset_n(reset_n), .bus(ifa));
   pc_src_ctrl #(.MEM_LAT(3), .EXC_BASE(8'd253)) dutB (.clk(clk), .reset_n(reset_n), .bus(ifb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   // Observed outputs per instance.
   logic       oReady[2], oPw[2], oEpc[2], oMem[2], oDone[2];
   logic [2:0] oSel[2];
   logic [7:0] oAddr[2];
   logic [1:0] oCause[2];

   always_comb begin
      oReady[0] = ifa.req_ready;  oReady[1] = ifb.req_ready;
      oPw[0]    = ifa.pc_write;   oPw[1]    = ifb.pc_write;
      oEpc[0]   = ifa.epc_write;  oEpc[1]   = ifb.epc_write;
      oMem[0]   = ifa.mem_rd;     oMem[1]   = ifb.mem_rd;
      oDone[0]  = ifa.done;       oDone[1]  = ifb.done;
      oSel[0]   = ifa.pc_src_sel; oSel[1]   = ifb.pc_src_sel;
      oAddr[0]  = ifa.exc_addr;   oAddr[1]  = ifb.exc_addr;
      oCause[0] = ifa.cause;      oCause[1] = ifb.cause;
   end

   task automatic cmp(input string name, input int inst, input int act, input int exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s inst%0d cycle %0d: got %0d, want %0d", name, inst, cyc, act, exp);
      end
   endtask

   // Timeline model: on an accept, future cycles get their expected events written in.
   int   lat[2] = '{1, 3};
   int   freeAt[2];
   int   mSel[2];
   int   mCause[2];
   bit   evPw[2][N];
   bit   evEpc[2][N];
   bit   evMem[2][N];
   bit   evDone[2][N];
   bit   evCauseV[2][N];
   int   evSel[2][N];
   int   evAddr[2][N];
   int   evCause[2][N];

   task automatic clearModel(input int i);
      freeAt[i] = 0;
      mSel[i]   = 0;
      mCause[i] = 0;
      for (int j = 0; j < N; j++) begin
         evPw[i][j] = 0; evEpc[i][j] = 0; evMem[i][j] = 0; evDone[i][j] = 0;
         evCauseV[i][j] = 0; evSel[i][j] = 0; evAddr[i][j] = 0; evCause[i][j] = 0;
      end
   endtask

   task automatic accept(input int i, input int n);
      int c;
      c = excOpc ? 1 : excOvf ? 2 : excDiv0 ? 3 : 0;
      evCauseV[i][n+1] = 1;
      evCause[i][n+1]  = c;
      if (c != 0) begin
         evEpc[i][n+1]          = 1;
         evMem[i][n+2]          = 1;
         evAddr[i][n+2]         = (253 + c - 1) % 256;
         evPw[i][n+3+lat[i]]    = 1;
         evSel[i][n+3+lat[i]]   = 5;
         evDone[i][n+3+lat[i]]  = 1;
         freeAt[i]              = n + 4 + lat[i];
      end else begin
         evDone[i][n+1] = 1;
         freeAt[i]      = n + 2;
         case (int'(reqKind))
            1: if (taken) begin evPw[i][n+1] = 1; evSel[i][n+1] = 1; end
            2: begin evPw[i][n+1] = 1; evSel[i][n+1] = 2; end
            3: begin evPw[i][n+1] = 1; evSel[i][n+1] = 3; end
            4: begin evPw[i][n+1] = 1; evSel[i][n+1] = 4; end
            default: begin evPw[i][n+1] = 1; evSel[i][n+1] = 0; end
         endcase
      end
   endtask

   initial begin
      clearModel(0);
      clearModel(1);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
               clearModel(i);
            end else begin
               if (evCauseV[i][cyc]) mCause[i] = evCause[i][cyc];
               if (evPw[i][cyc])     mSel[i]   = evSel[i][cyc];
            end
            cmp("req_ready", i, int'(oReady[i]), (cyc >= freeAt[i]) ? 1 : 0);
            cmp("pc_write",  i, int'(oPw[i]),    int'(evPw[i][cyc]));
            cmp("epc_write", i, int'(oEpc[i]),   int'(evEpc[i][cyc]));
            cmp("mem_rd",    i, int'(oMem[i]),   int'(evMem[i][cyc]));
            cmp("exc_addr",  i, int'(oAddr[i]),  evMem[i][cyc] ? evAddr[i][cyc] : 0);
            cmp("done",      i, int'(oDone[i]),  int'(evDone[i][cyc]));
            cmp("pc_src_sel", i, int'(oSel[i]),  mSel[i]);
            cmp("cause",     i, int'(oCause[i]), mCause[i]);
            if (reset_n && reqValid && cyc >= freeAt[i] && cyc + 12 < N) accept(i, cyc);
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] k, input logic tk, input logic o, input logic v,
                        input logic d);
      reqValid = 1'b1; reqKind = k; taken = tk; excOpc = o; excOvf = v; excDiv0 = d;
      step();
      reqValid = 1'b0; reqKind = 3'd0; taken = 1'b0;
      excOpc = 1'b0; excOvf = 1'b0; excDiv0 = 1'b0;
   endtask

   task automatic waitIdle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (ifa.req_ready && ifb.req_ready) ok = 1;
         else step();
      end
      cmp("idle_reached", 0, int'(ok), 1);
   endtask

   initial begin
      int cnt;
      reset_n = 1'b0;
      reqValid = 1'b0; reqKind = 3'd0; taken = 1'b0;
      excOpc = 1'b0; excOvf = 1'b0; excDiv0 = 1'b0;
      step();
      step();
      cmp("rst_ready", 0, int'(ifa.req_ready), 1);
      cmp("rst_cause", 1, int'(ifb.cause), 0);
      cmp("rst_sel",   0, int'(ifa.pc_src_sel), 0);
      reset_n = 1'b1;
      step();

      // NEXT: result one cycle after accept
      issue(3'd0, 0, 0, 0, 0);
      cmp("next_pw",   0, int'(ifa.pc_write), 1);
      cmp("next_sel",  0, int'(ifa.pc_src_sel), 0);
      cmp("next_done", 0, int'(ifa.done), 1);
      waitIdle();

      // JUMP then JR back-to-back, two cycles apart
      issue(3'd2, 0, 0, 0, 0);
      cmp("jump_sel", 0, int'(ifa.pc_src_sel), 2);
      reqValid = 1'b1; reqKind = 3'd3;
      step();
      cmp("jr_gap_pw", 0, int'(ifa.pc_write), 0);
      step();
      reqValid = 1'b0; reqKind = 3'd0;
      cmp("jr_pw",  0, int'(ifa.pc_write), 1);
      cmp("jr_sel", 0, int'(ifa.pc_src_sel), 3);
      waitIdle();

      // BRANCH not taken then taken
      issue(3'd1, 0, 0, 0, 0);
      cmp("bnt_done", 0, int'(ifa.done), 1);
      cmp("bnt_pw",   0, int'(ifa.pc_write), 0);
      cmp("bnt_sel",  0, int'(ifa.pc_src_sel), 3);
      waitIdle();
      issue(3'd1, 1, 0, 0, 0);
      cmp("bt_pw",  0, int'(ifa.pc_write), 1);
      cmp("bt_sel", 0, int'(ifa.pc_src_sel), 1);
      waitIdle();

      // Overflow exception on a NEXT request
      issue(3'd0, 0, 0, 1, 0);
      cmp("ovf_epc", 0, int'(ifa.epc_write), 1);
      step();
      cmp("ovf_mem",  0, int'(ifa.mem_rd), 1);
      cmp("ovf_addr", 0, int'(ifa.exc_addr), 254);
      step();
      step();
      cmp("ovf_pw",    0, int'(ifa.pc_write), 1);
      cmp("ovf_sel",   0, int'(ifa.pc_src_sel), 5);
      cmp("ovf_done",  0, int'(ifa.done), 1);
      cmp("ovf_cause", 0, int'(ifa.cause), 2);
      cmp("lat3_early", 1, int'(ifb.done), 0);
      step();
      step();
      cmp("lat3_done", 1, int'(ifb.done), 1);
      cmp("lat3_sel",  1, int'(ifb.pc_src_sel), 5);
      waitIdle();

      // All flags high, request held during the sequence, then RTE
      reqValid = 1'b1; reqKind = 3'd0; excOpc = 1'b1; excOvf = 1'b1; excDiv0 = 1'b1;
      step();
      reqKind = 3'd4; excOpc = 1'b0; excOvf = 1'b0; excDiv0 = 1'b0;
      cmp("hold_ready", 0, int'(ifa.req_ready), 0);
      step();
      cmp("all_addr",  0, int'(ifa.exc_addr), 253);
      cmp("all_cause", 0, int'(ifa.cause), 1);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         cnt++;
         if (ifa.pc_write && ifa.pc_src_sel == 3'd4) break;
      end
      reqValid = 1'b0; reqKind = 3'd0;
      cmp("rte_latency", 0, cnt, 4);
      cmp("rte_sel", 0, int'(ifa.pc_src_sel), 4);
      waitIdle();

      // Divide-by-zero alone
      issue(3'd0, 0, 0, 0, 1);
      step();
      cmp("div0_addr",  0, int'(ifa.exc_addr), 255);
      cmp("div0_cause", 1, int'(ifb.cause), 3);
      waitIdle();

      // Reset during EXC_WAIT of the MEM_LAT=3 instance
      issue(3'd0, 0, 0, 1, 0);
      step();
      step();
      reset_n = 1'b0;
      #1;
      cmp("rstw_ready", 1, int'(ifb.req_ready), 1);
      cmp("rstw_cause", 1, int'(ifb.cause), 0);
      cmp("rstw_pw",    1, int'(ifb.pc_write), 0);
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         cmp("rstw_no_pw", 1, int'(ifb.pc_write), 0);
      end
      waitIdle();

      // Illegal kind behaves as NEXT
      issue(3'd6, 0, 0, 0, 0);
      cmp("ill_pw",  0, int'(ifa.pc_write), 1);
      cmp("ill_sel", 0, int'(ifa.pc_src_sel), 0);
      waitIdle();

      // Flags without a request are ignored
      excOvf = 1'b1;
      step();
      step();
      excOvf = 1'b0;
      cmp("noreq_epc", 0, int'(ifa.epc_write), 0);
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
